vsmac_seq: RTL and testbench

- Sequencer for one vector-scalar MAC array (SIZE lanes, WIDTH bits, ACCUMULATIONS terms per result).
- Accepts operand pairs (vector a, scalar b) on a valid/ready stream.
- Drives the array's enable and accumulator clear, holding each operand pair for STEP_CYCLES cycles.
- Returns the final accumulated vector on a valid/ready result stream. Sits between the layer scheduler/operand buffers and the MAC array.

---
 rtl/vsmac_pkg.sv | 29 ++
 rtl/vsmac_seq_cnt.sv | 36 +++
 rtl/vsmac_seq.sv | 203 ++++++++++++++++++++
 tb/tb_vsmac_seq.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vsmac_pkg.sv
// vsmac_pkg: shared definitions for the vector-scalar MAC sequencer and its array bench.
// Holds the FSM state encoding, the default step length and small helper functions.
package vsmac_pkg;

  // Sequencer states; the encoding is shared with the array testbench.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_FETCH  = 3'd2,
    ST_RUN    = 3'd3,
    ST_SETTLE = 3'd4,
    ST_RESULT = 3'd5
  } vsmac_state_e;

  localparam int unsigned STEP_CYCLES_DEFAULT = 32'd2;

  // Bits needed to hold 0..max_val, never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    int unsigned w;
    w = $clog2(max_val + 32'd1);
    return (w < 32'd1) ? 32'd1 : w;
  endfunction

  // 32-bit increment that sticks at all-ones.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : (v + 32'd1);
  endfunction

endpackage

// File: rtl/vsmac_seq_cnt.sv
// vsmac_seq_cnt: up-counter 0..MAX with synchronous clear, enable and a
// terminal-count flag. Wraps back to zero when enabled at terminal count.
module vsmac_seq_cnt
  import vsmac_pkg::*;
#(
  parameter int unsigned MAX = 32'd1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam int unsigned W = cnt_width(MAX);

  logic [W-1:0] r_cnt;
  logic         w_tc;

  assign w_tc = (r_cnt == W'(MAX));
  assign o_tc = w_tc;

  // Count register: clear has priority, wrap to zero after the terminal value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_tc ? '0 : (r_cnt + W'(1));
    end else begin
      r_cnt <= r_cnt;
    end
  end

endmodule

// File: rtl/vsmac_seq.sv
// vsmac_seq: sequencer for one vector-scalar MAC array. Takes operand pairs on a
// valid/ready stream, holds each pair on the array for STEP_CYCLES enabled cycles,
// and returns the accumulated vector after ACCUMULATIONS pairs.
// Optional build macro VSMAC_SEQ_PERF_EN adds saturating performance counters.
module vsmac_seq
  import vsmac_pkg::*;
#(
  parameter int unsigned SIZE          = 32'd6,
  parameter int unsigned WIDTH         = 32'd8,
  parameter int unsigned ACCUMULATIONS = 32'd3,
  parameter int unsigned STEP_CYCLES   = STEP_CYCLES_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    op_valid,
  output logic                    op_ready,
  input  logic [WIDTH*SIZE-1:0]   op_a,
  input  logic [WIDTH-1:0]        op_b,
  output logic                    mac_clr,
  output logic                    mac_en,
  output logic [WIDTH*SIZE-1:0]   mac_a,
  output logic [WIDTH-1:0]        mac_b,
  input  logic [WIDTH*SIZE-1:0]   mac_out,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [WIDTH*SIZE-1:0]   res_data,
`ifdef VSMAC_SEQ_PERF_EN
  output logic [31:0]             perf_busy_cycles,
  output logic [31:0]             perf_stall_cycles,
  output logic [31:0]             perf_results,
`endif
  output logic                    busy
);

  vsmac_state_e            r_state;
  logic                    r_op_ready;
  logic                    r_mac_clr;
  logic                    r_mac_en;
  logic [WIDTH*SIZE-1:0]   r_mac_a;
  logic [WIDTH-1:0]        r_mac_b;
  logic                    r_res_valid;
  logic [WIDTH*SIZE-1:0]   r_res_data;
  logic                    r_busy;

  logic w_step_clr;
  logic w_step_en;
  logic w_step_tc;
  logic w_term_clr;
  logic w_term_en;
  logic w_term_tc;

  // Step counter runs only in RUN and restarts at zero for every operand pair.
  assign w_step_clr = (r_state != ST_RUN);
  assign w_step_en  = (r_state == ST_RUN);
  // Term counter restarts in CLEAR and advances on the last step of each pair.
  assign w_term_clr = (r_state == ST_CLEAR);
  assign w_term_en  = (r_state == ST_RUN) && w_step_tc;

  vsmac_seq_cnt #(.MAX(STEP_CYCLES - 32'd1)) u_step_cnt (
    .clk   (clk),
    .reset (reset),
    .i_clr (w_step_clr),
    .i_en  (w_step_en),
    .o_tc  (w_step_tc)
  );

  vsmac_seq_cnt #(.MAX(ACCUMULATIONS - 32'd1)) u_term_cnt (
    .clk   (clk),
    .reset (reset),
    .i_clr (w_term_clr),
    .i_en  (w_term_en),
    .o_tc  (w_term_tc)
  );

  // Control FSM with all outputs registered on the transition into each state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_op_ready  <= 1'b0;
      r_mac_clr   <= 1'b1;
      r_mac_en    <= 1'b0;
      r_mac_a     <= '0;
      r_mac_b     <= '0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_op_ready <= 1'b0;
          r_mac_en   <= 1'b0;
          if (op_valid) begin
            // Start a job; the operand stays on the bus until FETCH.
            r_state   <= ST_CLEAR;
            r_mac_clr <= 1'b1;
            r_busy    <= 1'b1;
          end else begin
            r_mac_clr <= 1'b0;
            r_busy    <= 1'b0;
          end
        end
        ST_CLEAR: begin
          r_mac_clr  <= 1'b0;
          r_op_ready <= 1'b1;
          r_state    <= ST_FETCH;
        end
        ST_FETCH: begin
          if (op_valid) begin
            r_mac_a    <= op_a;
            r_mac_b    <= op_b;
            r_op_ready <= 1'b0;
            r_mac_en   <= 1'b1;
            r_state    <= ST_RUN;
          end else begin
            // Operand stall: the array simply idles with enable low.
            r_mac_en <= 1'b0;
          end
        end
        ST_RUN: begin
          if (w_step_tc) begin
            r_mac_en <= 1'b0;
            if (w_term_tc) begin
              r_state <= ST_SETTLE;
            end else begin
              r_op_ready <= 1'b1;
              r_state    <= ST_FETCH;
            end
          end else begin
            r_mac_en <= 1'b1;
          end
        end
        ST_SETTLE: begin
          // The array's negedge output register has settled by now.
          r_res_data  <= mac_out;
          r_res_valid <= 1'b1;
          r_state     <= ST_RESULT;
        end
        ST_RESULT: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            if (op_valid) begin
              // Back-to-back job: clear first, the operand is taken in FETCH.
              r_mac_clr <= 1'b1;
              r_state   <= ST_CLEAR;
            end else begin
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
            end
          end else begin
            r_res_valid <= 1'b1;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_op_ready  <= 1'b0;
          r_mac_clr   <= 1'b1;
          r_mac_en    <= 1'b0;
          r_res_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign op_ready  = r_op_ready;
  assign mac_clr   = r_mac_clr;
  assign mac_en    = r_mac_en;
  assign mac_a     = r_mac_a;
  assign mac_b     = r_mac_b;
  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign busy      = r_busy;

`ifdef VSMAC_SEQ_PERF_EN
  logic [31:0] r_perf_busy;
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_results;
  logic        w_stall;
  logic        w_result_hs;

  assign w_stall     = ((r_state == ST_FETCH) && !op_valid) ||
                       ((r_state == ST_RESULT) && !res_ready);
  assign w_result_hs = (r_state == ST_RESULT) && res_ready;

  // Saturating activity counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_perf_busy    <= 32'd0;
      r_perf_stall   <= 32'd0;
      r_perf_results <= 32'd0;
    end else begin
      r_perf_busy    <= r_busy      ? sat_inc(r_perf_busy)    : r_perf_busy;
      r_perf_stall   <= w_stall     ? sat_inc(r_perf_stall)   : r_perf_stall;
      r_perf_results <= w_result_hs ? sat_inc(r_perf_results) : r_perf_results;
    end
  end

  assign perf_busy_cycles  = r_perf_busy;
  assign perf_stall_cycles = r_perf_stall;
  assign perf_results      = r_perf_results;
`endif

endmodule

// File: tb/tb_vsmac_seq.sv
// Self-checking bench for vsmac_seq with a behavioural MAC array model.
module tb_vsmac_seq;
  import vsmac_pkg::*;

  localparam int VW = 48;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          op_valid, op_ready;
  logic [VW-1:0] op_a;
  logic [7:0]    op_b;
  logic          mac_clr, mac_en;
  logic [VW-1:0] mac_a;
  logic [7:0]    mac_b;
  logic [VW-1:0] mac_out_m = '0;
  logic          res_valid, res_ready;
  logic [VW-1:0] res_data;
  logic          busy;
`ifdef VSMAC_SEQ_PERF_EN
  logic [31:0]   perf_busy_cycles, perf_stall_cycles, perf_results;
`endif

  vsmac_seq dut (
    .clk(clk), .reset(rst_n),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .mac_clr(mac_clr), .mac_en(mac_en), .mac_a(mac_a), .mac_b(mac_b),
    .mac_out(mac_out_m),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
`ifdef VSMAC_SEQ_PERF_EN
    .perf_busy_cycles(perf_busy_cycles), .perf_stall_cycles(perf_stall_cycles),
    .perf_results(perf_results),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int en_cnt = 0;
  int clr_cnt = 0;
  logic prev_clr = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  // Array model: one product per operand pair, taken on the first enabled edge.
  logic [VW-1:0] acc_m = '0;
  logic          prev_en_m = 1'b0;

  function automatic logic [VW-1:0] lanes_mac(input logic [VW-1:0] acc, input logic [VW-1:0] a,
                                              input logic [7:0] b);
    logic [VW-1:0] r;
    for (int i = 0; i < 6; i++) r[i*8 +: 8] = acc[i*8 +: 8] + 8'(a[i*8 +: 8] * b);
    return r;
  endfunction

  always @(posedge clk) begin
    if (mac_clr) acc_m <= '0;
    else if (mac_en && !prev_en_m) acc_m <= lanes_mac(acc_m, mac_a, mac_b);
    prev_en_m <= mac_en;
  end
  always @(negedge clk) mac_out_m <= acc_m;

  // Activity monitor: enabled cycles and clear pulses.
  always @(negedge clk) begin
    if (mac_en) en_cnt <= en_cnt + 1;
    if (mac_clr && !prev_clr) clr_cnt <= clr_cnt + 1;
    prev_clr <= mac_clr;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [VW-1:0] sb_q[$];

  // Wait for an operand handshake; returns the cycle count seen just before it.
  task automatic wait_op_hs(output int hs_at);
    bit ok;
    ok = 1'b0;
    hs_at = -1;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      if (op_ready && op_valid) begin
        ok = 1'b1;
        hs_at = cyc;
      end
    end
    if (!ok) begin
      errors++;
      $display("FAIL op_handshake: got timeout expected handshake");
    end
    @(posedge clk); #1;
  endtask

  task automatic run_job(input logic [VW-1:0] a, input logic [2:0][7:0] b, input logic [VW-1:0] exp,
                         input int stall_len, input int bp, input bit b2b,
                         input logic [VW-1:0] nxt_a, input logic [7:0] nxt_b);
    int t0, hs, en0, rise;
    bit ok;
    logic [VW-1:0] exp_q;
    en0 = en_cnt;
    sb_q.push_back(exp);
    res_ready = (bp == 0);
    op_a = a; op_b = b[0]; op_valid = 1'b1;
    wait_op_hs(t0);
    check("mac_a_latch0", mac_a, a);
    check("mac_b_latch0", mac_b, b[0]);
    for (int j = 1; j < 3; j++) begin
      op_a = a; op_b = b[j];
      if (j == 2 && stall_len > 0) begin
        op_valid = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 50 && !ok; k++) begin
          @(negedge clk);
          if (op_ready) ok = 1'b1;
        end
        if (!ok) begin
          errors++;
          $display("FAIL stall_fetch: got timeout expected op_ready");
        end
        for (int s = 0; s < stall_len; s++) begin
          check("stall_mac_en", mac_en, 1'b0);
          if (s < stall_len - 1) @(negedge clk);
        end
        @(posedge clk); #1;
        op_valid = 1'b1;
      end
      wait_op_hs(hs);
      check("mac_b_latch", mac_b, b[j]);
    end
    if (b2b) begin
      op_a = nxt_a; op_b = nxt_b; op_valid = 1'b1;
    end else begin
      op_valid = 1'b0;
    end
    rise = -1;
    ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      if (res_valid) begin
        ok = 1'b1;
        rise = cyc;
      end
    end
    check("latency", 64'(rise - t0), 64'(10 + stall_len));
    for (int s = 0; s < bp; s++) begin
      check("bp_res_valid", res_valid, 1'b1);
      check("bp_res_data", res_data, exp);
      check("bp_op_ready", op_ready, 1'b0);
      check("bp_mac_en", mac_en, 1'b0);
      @(negedge clk);
    end
    res_ready = 1'b1;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard: got result expected none");
    end else begin
      exp_q = sb_q.pop_front();
      check("res_data", res_data, exp_q);
    end
    @(posedge clk); #1;
    check("res_valid_drop", res_valid, 1'b0);
    check("mac_en_cycles", 64'(en_cnt - en0), 64'd6);
  endtask

  typedef struct {
    logic [VW-1:0]    a;
    logic [2:0][7:0]  b;
    logic [VW-1:0]    exp;
  } vec_t;

  vec_t vecs[5];
  int   h;
  int   clr0;
`ifdef VSMAC_SEQ_PERF_EN
  logic [31:0] ps0, pr0;
`endif

  initial begin
    vecs[0] = '{a: 48'h0101_0101_0101, b: {8'd4, 8'd3, 8'd2},       exp: 48'h0909_0909_0909};
    vecs[1] = '{a: 48'h0202_0202_0202, b: {8'd1, 8'd1, 8'd1},       exp: 48'h0606_0606_0606};
    vecs[2] = '{a: 48'h1010_1010_1010, b: {8'h01, 8'h10, 8'h10},    exp: 48'h1010_1010_1010};
    vecs[3] = '{a: 48'h0605_0403_0201, b: {8'd3, 8'd2, 8'd1},       exp: 48'h241E_1812_0C06};
    vecs[4] = '{a: 48'hFFFF_FFFF_FFFF, b: {8'h00, 8'h00, 8'hFF},    exp: 48'h0101_0101_0101};

    rst_n = 1'b0; op_valid = 1'b0; op_a = '0; op_b = '0; res_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_op_ready", op_ready, 1'b0);
    check("rst_mac_en", mac_en, 1'b0);
    check("rst_mac_clr", mac_clr, 1'b1);
    check("rst_mac_ab", {mac_a, mac_b}, 56'd0);
    check("rst_res", {res_valid, res_data}, 49'd0);
    check("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_mac_clr", mac_clr, 1'b0);
    check("idle_busy", busy, 1'b0);

    // Table of single jobs, no stalls, no backpressure.
    for (int i = 0; i < 5; i++) begin
      run_job(vecs[i].a, vecs[i].b, vecs[i].exp, 0, 0, 1'b0, '0, '0);
      repeat (2) @(posedge clk);
      #1;
    end

    // Operand stall of five FETCH cycles before the third term.
`ifdef VSMAC_SEQ_PERF_EN
    ps0 = perf_stall_cycles; pr0 = perf_results;
`endif
    run_job(vecs[0].a, vecs[0].b, vecs[0].exp, 5, 0, 1'b0, '0, '0);
`ifdef VSMAC_SEQ_PERF_EN
    check("perf_stall", perf_stall_cycles - ps0, 32'd5);
    check("perf_results", perf_results - pr0, 32'd1);
`endif
    repeat (2) @(posedge clk);
    #1;

    // Result backpressure for eight cycles.
    run_job(vecs[3].a, vecs[3].b, vecs[3].exp, 0, 8, 1'b0, '0, '0);
    repeat (2) @(posedge clk);
    #1;

    // Back-to-back jobs: exactly one clear pulse per job, no carry-over.
    clr0 = clr_cnt;
    run_job(vecs[0].a, vecs[0].b, vecs[0].exp, 0, 0, 1'b1, vecs[1].a, vecs[1].b[0]);
    check("b2b_busy", busy, 1'b1);
    run_job(vecs[1].a, vecs[1].b, vecs[1].exp, 0, 0, 1'b0, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    check("b2b_clr_pulses", 64'(clr_cnt - clr0), 64'd2);

    // Asynchronous reset during RUN of the third term.
    op_a = vecs[0].a; op_b = 8'd2; op_valid = 1'b1;
    wait_op_hs(h);
    op_b = 8'd3;
    wait_op_hs(h);
    op_b = 8'd4;
    wait_op_hs(h);
    op_valid = 1'b0;
    check("pre_rst_mac_en", mac_en, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_mac_en", mac_en, 1'b0);
    check("mid_rst_mac_clr", mac_clr, 1'b1);
    check("mid_rst_mac_ab", {mac_a, mac_b}, 56'd0);
    check("mid_rst_res", {res_valid, res_data}, 49'd0);
    check("mid_rst_ready_busy", {op_ready, busy}, 2'b00);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_job(vecs[0].a, vecs[0].b, vecs[0].exp, 0, 0, 1'b0, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    check("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
